// File: rtl/decoder_sequencer.sv
// Steps a 2-bit decoder select code through HOLD/UP/DOWN/PINGPONG patterns at a dwell rate.
// Define DSEQ_PINGPONG_EN to enable mode 11 PINGPONG; otherwise mode 11 behaves as UP.
module decoder_sequencer #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] mode,
   input  logic [7:0] dwell,
   input  logic [3:0] loops,
   output logic [1:0] sel,
   output logic       busy,
   output logic       step_tick,
   output logic       done
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic {StIdle, StRun} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    dwell_q, dwell_d;
   logic [3:0]    loops_q, loops_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    dcnt_q, dcnt_d;
   logic [3:0]    pass_q, pass_d;
   logic          step_q, step_d;
   logic          done_q, done_d;
   logic          wrap, step_ev, pass_end;
   logic [1:0]    next_sel;

`ifdef DSEQ_PINGPONG_EN
   logic          dir_q, dir_d, next_dir;
`endif

   assign wrap    = (pre_q == PW'(PRESCALE - 1));
   assign step_ev = (state_q == StRun) && wrap && (dcnt_q == dwell_q) && (mode_q != 2'b00);

   // Pattern decode: next code and whether this step closes a pass.
   always_comb begin
      next_sel = sel_q + 2'd1;
      pass_end = 1'b0;
`ifdef DSEQ_PINGPONG_EN
      next_dir = dir_q;
`endif
      case (mode_q)
         2'b10: begin
            next_sel = sel_q - 2'd1;
            pass_end = (sel_q == 2'd0);
         end
`ifdef DSEQ_PINGPONG_EN
         2'b11: begin
            if (!dir_q) begin
               next_sel = sel_q + 2'd1;
               if (sel_q == 2'd3) begin
                  next_sel = 2'd2;
                  next_dir = 1'b1;
               end
            end else begin
               next_sel = sel_q - 2'd1;
               if (sel_q == 2'd1) begin
                  pass_end = 1'b1;
                  next_dir = 1'b0;
               end
            end
         end
`endif
         default: begin
            next_sel = sel_q + 2'd1;
            pass_end = (sel_q == 2'd3);
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      dwell_d = dwell_q;
      loops_d = loops_q;
      pre_d   = pre_q;
      dcnt_d  = dcnt_q;
      pass_d  = pass_q;
      step_d  = 1'b0;
      done_d  = 1'b0;
`ifdef DSEQ_PINGPONG_EN
      dir_d   = dir_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               state_d = StRun;
               mode_d  = mode;
               dwell_d = dwell;
               loops_d = loops;
               pre_d   = '0;
               dcnt_d  = '0;
               pass_d  = '0;
               sel_d   = (mode == 2'b10) ? 2'd3 : 2'd0;
`ifdef DSEQ_PINGPONG_EN
               dir_d   = 1'b0;
`endif
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
            end else begin
               pre_d = wrap ? '0 : pre_q + PW'(1);
               if (wrap) dcnt_d = (dcnt_q == dwell_q) ? 8'd0 : dcnt_q + 8'd1;
               if (step_ev) begin
                  if (pass_end && (loops_q != 4'd0) && (pass_q + 4'd1 == loops_q)) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     sel_d  = next_sel;
                     step_d = 1'b1;
                     // Infinite runs never count passes, so the counter cannot wrap.
                     if (pass_end && (loops_q != 4'd0)) pass_d = pass_q + 4'd1;
`ifdef DSEQ_PINGPONG_EN
                     dir_d = next_dir;
`endif
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= 2'd0;
         mode_q  <= 2'd0;
         dwell_q <= 8'd0;
         loops_q <= 4'd0;
         pre_q   <= '0;
         dcnt_q  <= 8'd0;
         pass_q  <= 4'd0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DSEQ_PINGPONG_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         dwell_q <= dwell_d;
         loops_q <= loops_d;
         pre_q   <= pre_d;
         dcnt_q  <= dcnt_d;
         pass_q  <= pass_d;
         step_q  <= step_d;
         done_q  <= done_d;
`ifdef DSEQ_PINGPONG_EN
         dir_q   <= dir_d;
`endif
      end
   end

   assign sel       = sel_q;
   assign busy      = (state_q == StRun);
   assign step_tick = step_q;
   assign done      = done_q;

endmodule
